icache: RTL and testbench

- Direct-mapped, read-only instruction cache between the datapath's instruction fetch port and the memory controller's instruction port.
- Serves hits the same cycle the datapath presents `imemaddr`.
- On a miss, runs a one-word fill from memory, installs the word, then serves the hit.
- No writes and no coherence; `halt` has no effect on this block.

---
 rtl/icache.sv | 90 +++++++++
 tb/tb_icache.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are served combinationally from IDLE; misses run a single-word fill.
module icache #(
  parameter int unsigned SETS = 16,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [29:0]        r_miss_word;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_miss_idx;
  logic [TAG_W-1:0]   w_miss_tag;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill;
  logic               w_unused_lsb;

  assign w_idx        = imemaddr[IDX_W+1:2];
  assign w_tag        = imemaddr[31:IDX_W+2];
  assign w_miss_idx   = r_miss_word[IDX_W-1:0];
  assign w_miss_tag   = r_miss_word[29:IDX_W];
  assign w_unused_lsb = ^imemaddr[1:0];

  assign w_hit  = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss = (r_state == StIdle) & imemREN & ~w_hit;
  assign w_fill = (r_state == StFetch) & ~iwait;

  always_comb begin
    w_state_next = r_state;
    ihit         = 1'b0;
    imemload     = 32'h0;
    iREN         = 1'b0;
    iaddr        = 32'h0;
    unique case (r_state)
      StIdle: begin
        ihit     = w_hit;
        imemload = w_hit ? r_data[w_idx] : 32'h0;
        if (w_miss) w_state_next = StFetch;
      end
      StFetch: begin
        iREN  = 1'b1;
        iaddr = {r_miss_word, 2'b00};
        // A started fill always completes, regardless of the current request.
        if (!iwait) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= StIdle;
      r_miss_word <= '0;
      r_valid     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss) r_miss_word <= imemaddr[31:2];
      if (w_fill) r_valid[w_miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: scoreboard of expected fetch results
// against a small cache-state model and a behavioural memory responder.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  always #5 CLK = ~CLK;

  icache dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_valid;
  logic [25:0] m_tag [16];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8C01_0004;
      32'h0000_0004: return 32'h1111_1111;
      32'h0000_0044: return 32'h2222_2222;
      default:       return a ^ 32'hA5A5_0F0F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_valid[a[5:2]] = 1'b1;
    m_tag[a[5:2]]   = a[31:6];
  endtask

  task automatic sb_pop(input int lat);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check("imemload", imemload, e.data);
      check("hit_latency", lat, e.lat);
    end
  endtask

  // Full fetch: request addr, answer any fill after nwait busy cycles, compare on ihit.
  task automatic access(input logic [31:0] addr, input int nwait);
    logic [31:0] aligned;
    int          fetch;
    bit          done;
    aligned = {addr[31:2], 2'b00};
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = 32'h0;
    sb_q.push_back('{data: mem_f(aligned), lat: model_hit(aligned) ? 0 : nwait + 2});
    fetch = 0;
    done  = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge CLK);
      if (cyc == 0 && !ihit) check("iren_miss_cycle", iREN, 0);
      if (ihit) begin
        sb_pop(cyc);
        check("iren_on_hit", iREN, 0);
        done = 1'b1;
      end else if (iREN) begin
        check("iaddr", iaddr, aligned);
        if (fetch >= nwait) begin
          iwait = 1'b0;
          iload = mem_f(iaddr);
        end
        fetch++;
      end
    end
    if (!done) begin
      check("ihit_timeout", ihit, 1);
      sb_q.delete();
    end
    iwait = 1'b1;
    model_fill(aligned);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit done;
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    m_valid  = '0;
    #12;
    check("rst_ihit", ihit, 0);
    check("rst_iren", iREN, 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_imemload", imemload, 0);
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("idle_ihit", ihit, 0);
    check("idle_iren", iREN, 0);

    // Cold miss with two busy cycles, then five same-cycle hits.
    access(32'h0000_0000, 2);
    for (int i = 0; i < 5; i++) access(32'h0000_0000, 0);

    // Conflict eviction on index 1, then unaligned request.
    access(32'h0000_0004, 1);
    access(32'h0000_0044, 0);
    access(32'h0000_0004, 0);
    access(32'h0000_0044, 0);
    access(32'h0000_0007, 0);
    access(32'h0000_0004, 0);

    // Address change during a fill.
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0010;
    iwait    = 1'b1;
    @(negedge CLK);
    check("chg_miss_ihit", ihit, 0);
    @(posedge CLK);
    #1;
    imemaddr = 32'h0000_0020;
    @(negedge CLK);
    check("chg_iren", iREN, 1);
    check("chg_iaddr0", iaddr, 32'h0000_0010);
    @(negedge CLK);
    check("chg_iaddr1", iaddr, 32'h0000_0010);
    iwait = 1'b0;
    iload = mem_f(32'h0000_0010);
    @(posedge CLK);
    #1;
    iwait = 1'b1;
    model_fill(32'h0000_0010);
    @(negedge CLK);
    check("chg_idle_ihit", ihit, 0);
    check("chg_idle_iren", iREN, 0);
    @(negedge CLK);
    check("chg_fetch2_iren", iREN, 1);
    check("chg_fetch2_iaddr", iaddr, 32'h0000_0020);
    iwait = 1'b0;
    iload = mem_f(32'h0000_0020);
    sb_q.push_back('{data: mem_f(32'h0000_0020), lat: 1});
    done = 1'b0;
    for (int cyc = 1; cyc < 10 && !done; cyc++) begin
      @(negedge CLK);
      iwait = 1'b1;
      if (ihit) begin
        sb_pop(cyc);
        done = 1'b1;
      end
    end
    if (!done) begin
      check("chg_ihit_timeout", ihit, 1);
      sb_q.delete();
    end
    model_fill(32'h0000_0020);
    access(32'h0000_0010, 0);

    // Reset asserted mid-fill.
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0030;
    iwait    = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rstf_iren_pre", iREN, 1);
    #2;
    nRST    = 1'b0;
    imemREN = 1'b0;
    #1;
    check("rstf_iren", iREN, 0);
    check("rstf_iaddr", iaddr, 0);
    check("rstf_ihit", ihit, 0);
    @(negedge CLK);
    nRST    = 1'b1;
    m_valid = '0;
    access(32'h0000_0000, 0);
    access(32'h0000_0030, 1);
    access(32'h0000_0000, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
